// File: rtl/ssd_pkg.sv
// ssd_pkg -- shared constants for the seven-segment scan controller.
//
// Holds the 5-bit display codes for the non-hex glyphs, the all-segments-off
// pattern (segments are active-low), the blank power-on frame and a helper
// that turns a digit index into an active-low anode pattern.
package ssd_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [4:0] BLANK = 5'h10;
  localparam logic [4:0] DASH  = 5'h11;
  localparam logic [4:0] CH_C  = 5'h12;
  localparam logic [4:0] CH_L  = 5'h13;
  localparam logic [4:0] CH_O  = 5'h14;
  localparam logic [4:0] CH_P  = 5'h15;
  localparam logic [4:0] CH_E  = 5'h16;
  localparam logic [4:0] CH_N  = 5'h17;

  localparam logic [6:0]  SEG_OFF     = 7'h7F;
  localparam logic [19:0] FRAME_BLANK = {BLANK, BLANK, BLANK, BLANK};

  // Active-low anode pattern with only the selected digit driven low.
  function automatic logic [3:0] anode_of(input digit_idx_t idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/seg_code_decode.sv
// seg_code_decode -- combinational 5-bit display code to 7-segment decoder.
//
// Ports:
//   code : 5-bit display code (0x00-0x0F hex digits, 0x10-0x17 glyphs)
//   seg  : active-low segments {g,f,e,d,c,b,a}; unused codes are blank
module seg_code_decode
  import ssd_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  // Code lookup; anything not listed is blank.
  always_comb begin
    seg = SEG_OFF;
    case (code)
      5'h00:   seg = 7'h40;
      5'h01:   seg = 7'h79;
      5'h02:   seg = 7'h24;
      5'h03:   seg = 7'h30;
      5'h04:   seg = 7'h19;
      5'h05:   seg = 7'h12;
      5'h06:   seg = 7'h02;
      5'h07:   seg = 7'h78;
      5'h08:   seg = 7'h00;
      5'h09:   seg = 7'h10;
      5'h0A:   seg = 7'h08;
      5'h0B:   seg = 7'h03;
      5'h0C:   seg = 7'h46;
      5'h0D:   seg = 7'h21;
      5'h0E:   seg = 7'h06;
      5'h0F:   seg = 7'h0E;
      BLANK:   seg = SEG_OFF;
      DASH:    seg = 7'h3F;
      CH_C:    seg = 7'h46;
      CH_L:    seg = 7'h47;
      CH_O:    seg = 7'h23;
      CH_P:    seg = 7'h0C;
      CH_E:    seg = 7'h06;
      CH_N:    seg = 7'h2B;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl -- four-digit multiplexed seven-segment display scanner
// with double-buffered frame updates and optional per-digit blinking.
//
// Optional feature macro: SSD_BLINK_EN (blink counter and per-digit mask).
//
// Parameters:
//   REFRESH_DIV : clk cycles per digit slot
//   BLINK_DIV   : clk cycles per blink half-period (SSD_BLINK_EN only)
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-low reset
//   frame_in    : four 5-bit codes, [19:15] = digit 3 (leftmost), [4:0] = digit 0
//   blink_mask  : per-digit blink enable, bit n = digit n
//   frame_load  : request to display frame_in / blink_mask
//   frame_ack   : one-cycle pulse in the first cycle the requested frame shows
//   an          : active-low anodes, exactly one low outside reset
//   seg         : active-low segments {g,f,e,d,c,b,a}
//   blink_phase : 1 while blinking digits are blanked
//
// A new frame only takes effect at the scan boundary (digit 3 -> digit 0),
// so every scan shows one consistent frame. an/seg/frame_ack are registered
// from next-state values, so the new digit and its frame appear together in
// the cycle after the tick.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] frame_in,
  input  logic [3:0]  blink_mask,
  input  logic        frame_load,
  output logic        frame_ack,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        blink_phase
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [REF_W-1:0] ref_cnt_r;
  digit_idx_t       idx_r;
  digit_idx_t       idx_next_s;
  logic             tick_s;
  logic             boundary_s;
  logic [19:0]      act_frame_r;
  logic [19:0]      act_frame_next_s;
  logic [19:0]      pend_frame_r;
  logic             pend_r;
  logic [4:0]       code_s;
  logic [6:0]       dec_seg_s;
  logic             blank_s;

  assign tick_s     = (ref_cnt_r == REF_W'(REFRESH_DIV - 1));
  assign boundary_s = tick_s && (idx_r == 2'd3);

`ifdef SSD_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLK_W-1:0] blk_cnt_r;
  logic             phase_r;
  logic             phase_next_s;
  logic [3:0]       act_mask_r;
  logic [3:0]       act_mask_next_s;
  logic [3:0]       pend_mask_r;

  // Blink phase flips when the blink counter wraps.
  always_comb begin
    phase_next_s = phase_r;
    if (blk_cnt_r == BLK_W'(BLINK_DIV - 1)) begin
      phase_next_s = ~phase_r;
    end else begin
      phase_next_s = phase_r;
    end
  end

  // Mask follows the same boundary hand-over as the frame codes.
  always_comb begin
    act_mask_next_s = act_mask_r;
    if (boundary_s && frame_load) begin
      act_mask_next_s = blink_mask;
    end else if (boundary_s && pend_r) begin
      act_mask_next_s = pend_mask_r;
    end else begin
      act_mask_next_s = act_mask_r;
    end
  end

  // Blink counter, phase and mask storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt_r   <= '0;
      phase_r     <= 1'b0;
      act_mask_r  <= 4'b0000;
      pend_mask_r <= 4'b0000;
    end else begin
      if (blk_cnt_r == BLK_W'(BLINK_DIV - 1)) begin
        blk_cnt_r <= '0;
      end else begin
        blk_cnt_r <= blk_cnt_r + BLK_W'(1);
      end
      phase_r    <= phase_next_s;
      act_mask_r <= act_mask_next_s;
      if (frame_load && !boundary_s) begin
        pend_mask_r <= blink_mask;
      end
    end
  end

  assign blank_s     = phase_next_s && act_mask_next_s[idx_next_s];
  assign blink_phase = phase_r;
`else
  logic unused_blink_s;

  assign unused_blink_s = (^blink_mask) ^ (BLINK_DIV > 0);
  assign blank_s        = 1'b0;
  assign blink_phase    = 1'b0;
`endif

  // Next digit index and next active frame (loads at the boundary bypass pending).
  always_comb begin
    idx_next_s       = idx_r;
    act_frame_next_s = act_frame_r;
    if (tick_s) begin
      idx_next_s = idx_r + 2'd1;
    end else begin
      idx_next_s = idx_r;
    end
    if (boundary_s && frame_load) begin
      act_frame_next_s = frame_in;
    end else if (boundary_s && pend_r) begin
      act_frame_next_s = pend_frame_r;
    end else begin
      act_frame_next_s = act_frame_r;
    end
  end

  // Select the code of the digit that will be lit next cycle.
  always_comb begin
    code_s = BLANK;
    case (idx_next_s)
      2'd0:    code_s = act_frame_next_s[4:0];
      2'd1:    code_s = act_frame_next_s[9:5];
      2'd2:    code_s = act_frame_next_s[14:10];
      2'd3:    code_s = act_frame_next_s[19:15];
      default: code_s = BLANK;
    endcase
  end

  seg_code_decode u_decode (
    .code (code_s),
    .seg  (dec_seg_s)
  );

  // Refresh counter, scan index, frame buffers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt_r    <= '0;
      idx_r        <= 2'd0;
      act_frame_r  <= FRAME_BLANK;
      pend_frame_r <= FRAME_BLANK;
      pend_r       <= 1'b0;
      frame_ack    <= 1'b0;
      an           <= 4'b1111;
      seg          <= SEG_OFF;
    end else begin
      if (tick_s) begin
        ref_cnt_r <= '0;
      end else begin
        ref_cnt_r <= ref_cnt_r + REF_W'(1);
      end
      idx_r       <= idx_next_s;
      act_frame_r <= act_frame_next_s;
      // Latest request wins; the boundary consumes whatever is pending.
      if (boundary_s) begin
        pend_r <= 1'b0;
      end else if (frame_load) begin
        pend_r       <= 1'b1;
        pend_frame_r <= frame_in;
      end
      frame_ack <= boundary_s && (frame_load || pend_r);
      an        <= anode_of(idx_next_s);
      seg       <= blank_s ? SEG_OFF : dec_seg_s;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl -- directed, table-driven bench for ssd_scan_ctrl
// (REFRESH_DIV=4, BLINK_DIV=16). Blink expectations follow SSD_BLINK_EN.
module tb_ssd_scan_ctrl;

`ifdef SSD_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [19:0] frame_in;
  logic [3:0]  blink_mask;
  logic        frame_load;
  logic        frame_ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        blink_phase;

  int n_pass;
  int n_total;

  ssd_scan_ctrl #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_in    (frame_in),
    .blink_mask  (blink_mask),
    .frame_load  (frame_load),
    .frame_ack   (frame_ack),
    .an          (an),
    .seg         (seg),
    .blink_phase (blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          ncyc;
    bit          load;
    logic [19:0] frame;
    logic [3:0]  mask;
    logic [3:0]  an;
    logic [6:0]  seg_b;
    logic [6:0]  seg_n;
    bit          ack;
    bit          ph;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] hi_tab [32];

  function automatic vec_t mk(string nm, int n, bit ld, logic [19:0] fr, logic [3:0] mk_,
                              logic [3:0] a, logic [6:0] sb, logic [6:0] sn, bit ak, bit p);
    vec_t v;
    v.name = nm; v.ncyc = n; v.load = ld; v.frame = fr; v.mask = mk_;
    v.an = a; v.seg_b = sb; v.seg_n = sn; v.ack = ak; v.ph = p;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [6:0] exp_seg(logic [4:0] code);
    logic [6:0] hi;
    hi = hi_tab[code];
    return ~hi;
  endfunction

  logic [19:0] fa, fb1, fb2, fc, fd, fk;
  logic [4:0]  c0;
  bit          saw_ack;

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b0; frame_in = 20'h0; blink_mask = 4'b0000; frame_load = 1'b0;

    // Active-high {g,f,e,d,c,b,a} reference glyphs.
    hi_tab[0]  = 7'h3F; hi_tab[1]  = 7'h06; hi_tab[2]  = 7'h5B; hi_tab[3]  = 7'h4F;
    hi_tab[4]  = 7'h66; hi_tab[5]  = 7'h6D; hi_tab[6]  = 7'h7D; hi_tab[7]  = 7'h07;
    hi_tab[8]  = 7'h7F; hi_tab[9]  = 7'h6F; hi_tab[10] = 7'h77; hi_tab[11] = 7'h7C;
    hi_tab[12] = 7'h39; hi_tab[13] = 7'h5E; hi_tab[14] = 7'h79; hi_tab[15] = 7'h71;
    hi_tab[16] = 7'h00; hi_tab[17] = 7'h40; hi_tab[18] = 7'h39; hi_tab[19] = 7'h38;
    hi_tab[20] = 7'h5C; hi_tab[21] = 7'h73; hi_tab[22] = 7'h79; hi_tab[23] = 7'h54;
    for (int i = 24; i < 32; i++) hi_tab[i] = 7'h00;

    fa  = {5'h12, 5'h13, 5'h05, 5'h0D};
    fb1 = {5'h01, 5'h01, 5'h01, 5'h01};
    fb2 = {5'h02, 5'h02, 5'h02, 5'h02};
    fc  = {5'h14, 5'h15, 5'h16, 5'h17};
    fd  = {5'h08, 5'h01, 5'h02, 5'h03};

    //            name          n  ld frame mask  an     seg_b  seg_n  ack ph
    vecs.push_back(mk("rel_first",  1, 0, 20'h0, 4'h0, 4'hE, 7'h7F, 7'h7F, 0, 0));
    vecs.push_back(mk("tick1",      3, 0, 20'h0, 4'h0, 4'hD, 7'h7F, 7'h7F, 0, 0));
    vecs.push_back(mk("load_mid",   2, 1, fa,    4'h0, 4'hD, 7'h7F, 7'h7F, 0, 0));
    vecs.push_back(mk("tick2",      2, 0, 20'h0, 4'h0, 4'hB, 7'h7F, 7'h7F, 0, 0));
    vecs.push_back(mk("pre_bnd",    7, 0, 20'h0, 4'h0, 4'h7, 7'h7F, 7'h7F, 0, 0));
    vecs.push_back(mk("bnd_ack",    1, 0, 20'h0, 4'h0, 4'hE, 7'h21, 7'h21, 1, 1));
    vecs.push_back(mk("ack_one",    1, 0, 20'h0, 4'h0, 4'hE, 7'h21, 7'h21, 0, 1));
    vecs.push_back(mk("d1_5",       3, 0, 20'h0, 4'h0, 4'hD, 7'h12, 7'h12, 0, 1));
    vecs.push_back(mk("d2_L",       4, 0, 20'h0, 4'h0, 4'hB, 7'h47, 7'h47, 0, 1));
    vecs.push_back(mk("d3_C",       4, 0, 20'h0, 4'h0, 4'h7, 7'h46, 7'h46, 0, 1));
    vecs.push_back(mk("no_reack",   4, 0, 20'h0, 4'h0, 4'hE, 7'h21, 7'h21, 0, 0));
    vecs.push_back(mk("load_b1",    2, 1, fb1,   4'h0, 4'hE, 7'h21, 7'h21, 0, 0));
    vecs.push_back(mk("load_b2",    4, 1, fb2,   4'h0, 4'hD, 7'h12, 7'h12, 0, 0));
    vecs.push_back(mk("pre_bnd2",   9, 0, 20'h0, 4'h0, 4'h7, 7'h46, 7'h46, 0, 0));
    vecs.push_back(mk("merged_ack", 1, 0, 20'h0, 4'h0, 4'hE, 7'h24, 7'h24, 1, 1));
    vecs.push_back(mk("merged_one", 1, 0, 20'h0, 4'h0, 4'hE, 7'h24, 7'h24, 0, 1));
    vecs.push_back(mk("pre_byp",   14, 0, 20'h0, 4'h0, 4'h7, 7'h24, 7'h24, 0, 1));
    vecs.push_back(mk("bypass",     1, 1, fc,    4'h0, 4'hE, 7'h2B, 7'h2B, 1, 0));
    vecs.push_back(mk("byp_d1",     4, 0, 20'h0, 4'h0, 4'hD, 7'h06, 7'h06, 0, 0));
    vecs.push_back(mk("byp_d2",     4, 0, 20'h0, 4'h0, 4'hB, 7'h0C, 7'h0C, 0, 0));
    vecs.push_back(mk("byp_d3",     4, 0, 20'h0, 4'h0, 4'h7, 7'h23, 7'h23, 0, 0));
    vecs.push_back(mk("blink_ld",   4, 1, fd,    4'h8, 4'hE, 7'h30, 7'h30, 1, 1));
    vecs.push_back(mk("blink_d3",  12, 0, 20'h0, 4'h0, 4'h7, 7'h7F, 7'h00, 0, 1));
    vecs.push_back(mk("blink_off",  4, 0, 20'h0, 4'h0, 4'hE, 7'h30, 7'h30, 0, 0));
    vecs.push_back(mk("blink_d3on",12, 0, 20'h0, 4'h0, 4'h7, 7'h00, 7'h00, 0, 0));
    vecs.push_back(mk("blink_d1",   8, 0, 20'h0, 4'h0, 4'hD, 7'h24, 7'h24, 0, 1));
    vecs.push_back(mk("blink_d3b",  8, 0, 20'h0, 4'h0, 4'h7, 7'h7F, 7'h00, 0, 1));

    // Reset values while held in reset.
    step(); step();
    chk("rst_an",    {28'h0, an},          32'hF);
    chk("rst_seg",   {25'h0, seg},         32'h7F);
    chk("rst_ack",   {31'h0, frame_ack},   32'h0);
    chk("rst_phase", {31'h0, blink_phase}, 32'h0);
    rst = 1'b1;

    // Table: load is presented for the first edge of each entry only.
    foreach (vecs[i]) begin
      frame_load = vecs[i].load;
      frame_in   = vecs[i].frame;
      blink_mask = vecs[i].mask;
      step();
      frame_load = 1'b0;
      for (int c = 1; c < vecs[i].ncyc; c++) step();
      chk({vecs[i].name, "_an"},  {28'h0, an}, {28'h0, vecs[i].an});
      chk({vecs[i].name, "_seg"}, {25'h0, seg},
          {25'h0, (BLINK_EN ? vecs[i].seg_b : vecs[i].seg_n)});
      chk({vecs[i].name, "_ack"}, {31'h0, frame_ack}, {31'h0, vecs[i].ack});
      chk({vecs[i].name, "_ph"},  {31'h0, blink_phase}, {31'h0, (vecs[i].ph & BLINK_EN)});
    end

    // Decoder sweep: one frame per scan, each digit checked in its slot.
    for (int k = 0; k < 8; k++) begin
      c0 = 5'(4 * k);
      fk = {c0 + 5'd3, c0 + 5'd2, c0 + 5'd1, c0};
      frame_load = 1'b1; frame_in = fk; blink_mask = 4'b0000;
      step();
      frame_load = 1'b0;
      step(); step(); step();
      chk("sweep_ack", {31'h0, frame_ack}, 32'h1);
      for (int d = 0; d < 4; d++) begin
        if (d != 0) begin
          step(); step(); step(); step();
        end
        chk("sweep_an",  {28'h0, an},  {28'h0, ~(4'b0001 << d)});
        chk("sweep_seg", {25'h0, seg}, {25'h0, exp_seg(c0 + 5'(d))});
      end
    end

    // Reset while a frame is pending.
    frame_load = 1'b1; frame_in = fa; blink_mask = 4'b1111;
    step();
    frame_load = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_an",  {28'h0, an},          32'hF);
    chk("mid_rst_seg", {25'h0, seg},         32'h7F);
    chk("mid_rst_ack", {31'h0, frame_ack},   32'h0);
    chk("mid_rst_ph",  {31'h0, blink_phase}, 32'h0);
    step(); step();
    rst = 1'b1;
    saw_ack = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (frame_ack) saw_ack = 1'b1;
      if (c == 1) begin
        chk("rel2_an",  {28'h0, an},  32'hE);
        chk("rel2_seg", {25'h0, seg}, 32'h7F);
      end
      if (c == 3) chk("rel2_pre_tick", {28'h0, an}, 32'hE);
      if (c == 4) chk("rel2_tick",     {28'h0, an}, 32'hD);
      if (c == 16) begin
        chk("rel2_bnd_an",  {28'h0, an},  32'hE);
        chk("rel2_bnd_seg", {25'h0, seg}, 32'h7F);
      end
    end
    chk("rel2_no_ack", {31'h0, saw_ack}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
